varray_queue: RTL and testbench

VARRAY_QUEUE -- requirements
Module: varray_queue

---
 rtl/varray_pkg.sv | 21 ++
 rtl/varray_entry_ram.sv | 27 ++
 rtl/varray_queue.sv | 141 ++++++++++++++
 tb/tb_varray_queue.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/varray_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | varray_pkg : default parameters and queue entry layout for varray     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package varray_pkg;

   localparam int VARRAY_ELEM_W     = 18;
   localparam int VARRAY_ADDR_BITS  = 16;
   localparam int VARRAY_LOG_DEPTH  = 6;
   localparam int VARRAY_LEN_BITS   = 4;
   localparam int VARRAY_FILL_VALUE = 0;

   typedef struct packed {
      logic [VARRAY_ADDR_BITS-1:0] start;
      logic [VARRAY_LEN_BITS-1:0]  len;
      logic [VARRAY_ELEM_W-1:0]    data;
   } varray_entry_t;

endpackage
`default_nettype wire

// File: rtl/varray_entry_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | varray_entry_ram : run-queue storage, sync write, async read          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module varray_entry_ram #(
   parameter int LOG_DEPTH = 6,
   parameter int WIDTH     = 38
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [LOG_DEPTH-1:0] waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic [LOG_DEPTH-1:0] raddr,
   output logic [WIDTH-1:0]     rdata
);

   logic [WIDTH-1:0] mem_q [2**LOG_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/varray_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | varray_queue : sparse virtual array built from a queue of data runs   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module varray_queue
   import varray_pkg::*;
#(
   parameter int                 ELEM_W     = VARRAY_ELEM_W,
   parameter int                 ADDR_BITS  = VARRAY_ADDR_BITS,
   parameter int                 LOG_DEPTH  = VARRAY_LOG_DEPTH,
   parameter int                 LEN_BITS   = VARRAY_LEN_BITS,
   parameter logic [ELEM_W-1:0]  FILL_VALUE = ELEM_W'(VARRAY_FILL_VALUE)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   we,
   input  logic [ADDR_BITS-1:0]   write_addr,
   input  logic [LEN_BITS-1:0]    write_len,
   input  logic [ELEM_W-1:0]      dat_w,
   output logic                   full,
   input  logic                   re,
   input  logic [ADDR_BITS-1:0]   read_addr,
   output logic [ELEM_W-1:0]      dat_r,
   output logic                   rvalid,
   output logic                   hole,
   output logic                   err,
   output logic [ADDR_BITS:0]     varray_len,
   output logic [LOG_DEPTH:0]     count
);

   localparam logic [LOG_DEPTH:0] DEPTH_CNT = (LOG_DEPTH+1)'(2**LOG_DEPTH);

   typedef struct packed {
      logic [ADDR_BITS-1:0] start;
      logic [LEN_BITS-1:0]  len;
      logic [ELEM_W-1:0]    data;
   } entry_t;

   logic [LOG_DEPTH-1:0] head_q, head_d, tail_q, tail_d;
   logic [LOG_DEPTH:0]   count_q, count_d;
   logic [ADDR_BITS:0]   varray_len_q, varray_len_d;
   logic [ADDR_BITS-1:0] last_raddr_q, last_raddr_d;
   logic [ELEM_W-1:0]    dat_r_q, dat_r_d;
   logic                 rvalid_q, rvalid_d, hole_q, hole_d, err_q, err_d;

   entry_t             wr_ent, tail_ent;
   logic               accept, retire, is_full;
   logic [ADDR_BITS:0] ra_ext, rd_start, rd_end, wr_end;

   assign wr_ent = '{start: write_addr, len: write_len, data: dat_w};

   varray_entry_ram #(
      .LOG_DEPTH (LOG_DEPTH),
      .WIDTH     ($bits(entry_t))
   ) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr (head_q),
      .wdata (wr_ent),
      .raddr (tail_q),
      .rdata (tail_ent)
   );

   // Run bounds are widened by one bit so a run ending at 2**ADDR_BITS does not wrap.
   assign is_full  = (count_q == DEPTH_CNT);
   assign ra_ext   = {1'b0, read_addr};
   assign rd_start = {1'b0, tail_ent.start};
   assign rd_end   = rd_start + (ADDR_BITS+1)'(tail_ent.len);
   assign wr_end   = {1'b0, write_addr} + (ADDR_BITS+1)'(write_len);

   always_comb begin
      retire       = 1'b0;
      err_d        = err_q;
      hole_d       = 1'b0;
      rvalid_d     = re;
      dat_r_d      = dat_r_q;
      last_raddr_d = last_raddr_q;
      if (re) begin
         last_raddr_d = read_addr;
         if (read_addr < last_raddr_q) begin
            err_d   = 1'b1;
            dat_r_d = FILL_VALUE;
            hole_d  = 1'b1;
         end else if (count_q == '0 || ra_ext < rd_start) begin
            dat_r_d = FILL_VALUE;
            hole_d  = 1'b1;
         end else if (ra_ext < rd_end) begin
            dat_r_d = tail_ent.data;
            retire  = (ra_ext == rd_end - 1'b1);
         end else begin
            err_d   = 1'b1;
            dat_r_d = FILL_VALUE;
            hole_d  = 1'b1;
         end
      end

      accept = we && (write_len != '0) && ({1'b0, write_addr} >= varray_len_q)
               && (!is_full || retire);
      if (we && !accept) err_d = 1'b1;

      head_d       = accept ? head_q + 1'b1 : head_q;
      tail_d       = retire ? tail_q + 1'b1 : tail_q;
      varray_len_d = accept ? wr_end : varray_len_q;
      count_d      = count_q + (LOG_DEPTH+1)'(accept) - (LOG_DEPTH+1)'(retire);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         varray_len_q <= '0;
         last_raddr_q <= '0;
         dat_r_q      <= FILL_VALUE;
         rvalid_q     <= 1'b0;
         hole_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         varray_len_q <= varray_len_d;
         last_raddr_q <= last_raddr_d;
         dat_r_q      <= dat_r_d;
         rvalid_q     <= rvalid_d;
         hole_q       <= hole_d;
         err_q        <= err_d;
      end
   end

   assign full       = is_full;
   assign dat_r      = dat_r_q;
   assign rvalid     = rvalid_q;
   assign hole       = hole_q;
   assign err        = err_q;
   assign varray_len = varray_len_q;
   assign count      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_varray_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_varray_queue : directed self-checking bench for varray_queue       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_varray_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [15:0] write_addr;
   logic [3:0]  write_len;
   logic [17:0] dat_w;
   logic        full;
   logic        re;
   logic [15:0] read_addr;
   logic [17:0] dat_r;
   logic        rvalid;
   logic        hole;
   logic        err;
   logic [16:0] varray_len;
   logic [6:0]  count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   varray_queue dut (
      .clk        (clk),
      .reset      (reset),
      .we         (we),
      .write_addr (write_addr),
      .write_len  (write_len),
      .dat_w      (dat_w),
      .full       (full),
      .re         (re),
      .read_addr  (read_addr),
      .dat_r      (dat_r),
      .rvalid     (rvalid),
      .hole       (hole),
      .err        (err),
      .varray_len (varray_len),
      .count      (count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [15:0] wa, input logic [3:0] wl,
                        input logic [17:0] d, input logic r, input logic [15:0] ra);
      we = w; write_addr = wa; write_len = wl; dat_w = d; re = r; read_addr = ra;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_dat_r"}, 32'(dat_r), 32'h0);
      chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
      chk({tag, "_hole"}, 32'(hole), 32'h0);
      chk({tag, "_err"}, 32'(err), 32'h0);
      chk({tag, "_full"}, 32'(full), 32'h0);
      chk({tag, "_vlen"}, 32'(varray_len), 32'h0);
      chk({tag, "_count"}, 32'(count), 32'h0);
   endtask

   task automatic chk_rd(input string tag, input logic [17:0] d, input logic h);
      chk({tag, "_rvalid"}, 32'(rvalid), 32'h1);
      chk({tag, "_dat_r"}, 32'(dat_r), 32'(d));
      chk({tag, "_hole"}, 32'(hole), 32'(h));
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk_reset_state("rst");
      reset = 1'b0;

      // Single run of four elements read back in order.
      drive(1, 16'd0, 4'd4, 18'h155, 0, 0);
      tick();
      chk("w0_count", 32'(count), 32'd1);
      chk("w0_vlen", 32'(varray_len), 32'd4);
      for (int a = 0; a < 4; a++) begin
         drive(0, 0, 0, 0, 1, 16'(a));
         tick();
         chk_rd($sformatf("r0_%0d", a), 18'h155, 1'b0);
         chk($sformatf("r0_%0d_count", a), 32'(count), (a == 3) ? 32'd0 : 32'd1);
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk("idle_rvalid", 32'(rvalid), 32'h0);

      // Gap before a run reads as holes.
      drive(1, 16'd10, 4'd2, 18'd7, 0, 0);
      tick();
      chk("w1_vlen", 32'(varray_len), 32'd12);
      drive(0, 0, 0, 0, 1, 16'd8);  tick(); chk_rd("r1_8", 18'd0, 1'b1);
      drive(0, 0, 0, 0, 1, 16'd9);  tick(); chk_rd("r1_9", 18'd0, 1'b1);
      drive(0, 0, 0, 0, 1, 16'd10); tick(); chk_rd("r1_10", 18'd7, 1'b0);
      drive(0, 0, 0, 0, 1, 16'd11); tick(); chk_rd("r1_11", 18'd7, 1'b0);
      chk("r1_count", 32'(count), 32'd0);
      chk("r1_err", 32'(err), 32'd0);

      // Fill the queue, then overflow with and without a retiring read.
      for (int i = 0; i < 64; i++) begin
         drive(1, 16'(100 + i), 4'd1, 18'(i + 1), 0, 0);
         tick();
      end
      chk("fill_count", 32'(count), 32'd64);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_err", 32'(err), 32'd0);
      drive(1, 16'd200, 4'd1, 18'h99, 0, 0);
      tick();
      chk("ovf_err", 32'(err), 32'd1);
      chk("ovf_count", 32'(count), 32'd64);
      chk("ovf_vlen", 32'(varray_len), 32'd164);
      drive(1, 16'd200, 4'd1, 18'h99, 1, 16'd100);
      tick();
      chk("swap_count", 32'(count), 32'd64);
      chk("swap_vlen", 32'(varray_len), 32'd201);
      chk("swap_full", 32'(full), 32'd1);
      chk_rd("swap_rd", 18'd1, 1'b0);

      // Reset wins over concurrent write and read.
      drive(1, 16'd300, 4'd1, 18'h5, 1, 16'd101);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      chk_reset_state("rst2");

      // Run ending exactly at the top of the address space.
      drive(1, 16'd65534, 4'd2, 18'h3abc, 0, 0);
      tick();
      chk("top_vlen", 32'(varray_len), 32'h10000);
      drive(0, 0, 0, 0, 1, 16'd65534); tick(); chk_rd("top_r0", 18'h3abc, 1'b0);
      chk("top_r0_count", 32'(count), 32'd1);
      drive(0, 0, 0, 0, 1, 16'd65535); tick(); chk_rd("top_r1", 18'h3abc, 1'b0);
      chk("top_r1_count", 32'(count), 32'd0);
      chk("top_err", 32'(err), 32'd0);

      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;

      // Overlapping write and backwards read.
      drive(1, 16'd5, 4'd3, 18'h22, 0, 0);  tick();
      drive(1, 16'd6, 4'd1, 18'h33, 0, 0);  tick();
      chk("ovl_err", 32'(err), 32'd1);
      chk("ovl_count", 32'(count), 32'd1);
      chk("ovl_vlen", 32'(varray_len), 32'd8);
      drive(0, 0, 0, 0, 1, 16'd7); tick(); chk_rd("ovl_r7", 18'h22, 1'b0);
      chk("ovl_r7_count", 32'(count), 32'd0);
      drive(0, 0, 0, 0, 1, 16'd6); tick(); chk_rd("ovl_r6", 18'd0, 1'b1);
      chk("ovl_r6_err", 32'(err), 32'd1);

      // Zero-length write is an error; read past the tail run is an error.
      reset = 1'b1; drive(0, 0, 0, 0, 0, 0); tick(); reset = 1'b0;
      drive(1, 16'd3, 4'd0, 18'h1, 0, 0); tick();
      chk("zl_err", 32'(err), 32'd1);
      chk("zl_count", 32'(count), 32'd0);
      reset = 1'b1; drive(0, 0, 0, 0, 0, 0); tick(); reset = 1'b0;
      drive(1, 16'd2, 4'd2, 18'h11, 0, 0); tick();
      drive(0, 0, 0, 0, 1, 16'd4); tick(); chk_rd("past_rd", 18'd0, 1'b1);
      chk("past_err", 32'(err), 32'd1);
      chk("past_count", 32'(count), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
